// File: rtl/rv_pkg.sv
// Shared types and encodings for the RV32I-subset multi-cycle core.
package rv_pkg;

  // ALU operation codes as seen by the datapath ALU
  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_t;

  // Control FSM states; the numeric value is exported on state_o
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } ctrl_state_t;

  // Major opcodes
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Datapath select encodings
  localparam logic       A_SEL_RS1     = 1'b0;
  localparam logic       A_SEL_PC      = 1'b1;
  localparam logic [1:0] B_SEL_RS2     = 2'd0;
  localparam logic [1:0] B_SEL_IMM     = 2'd1;
  localparam logic [1:0] B_SEL_FOUR    = 2'd2;
  localparam logic [1:0] IMM_SEL_I     = 2'd0;
  localparam logic [1:0] IMM_SEL_S     = 2'd1;
  localparam logic [1:0] IMM_SEL_B     = 2'd2;
  localparam logic       PC_SRC_ALU    = 1'b0;
  localparam logic       PC_SRC_ALUOUT = 1'b1;
  localparam logic       WD_ALUOUT     = 1'b0;
  localparam logic       WD_MEM        = 1'b1;

endpackage

// File: rtl/rv_alu_dec.sv
// Maps opcode class and funct3/funct7 to an ALU operation and flags
// instructions outside the supported RV32I subset as illegal.
module rv_alu_dec
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    aluop,
  output logic       legal
);

  alu_op_t base_op;

  // Operation implied by funct3 alone, shared by R-type and I-type
  always_comb begin
    base_op = ALU_ADD;
    case (funct3)
      F3_ADD_SUB: base_op = ALU_ADD;
      F3_SLL:     base_op = ALU_SLL;
      F3_SLT:     base_op = ALU_SLT;
      F3_XOR:     base_op = ALU_XOR;
      F3_SRL_SRA: base_op = ALU_SRL;
      F3_OR:      base_op = ALU_OR;
      F3_AND:     base_op = ALU_AND;
      default:    base_op = ALU_ADD;
    endcase
  end

  // Final operation and legality per opcode class; SLTU/SLTIU and SRA/SRAI are rejected
  always_comb begin
    aluop = ALU_ADD;
    legal = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          aluop = ALU_SUB;
          legal = 1'b1;
        end else begin
          aluop = base_op;
          legal = (funct7 == F7_BASE) && (funct3 != 3'b011);
        end
      end
      OPC_ITYPE: begin
        aluop = base_op;
        case (funct3)
          F3_SLL, F3_SRL_SRA: legal = (funct7 == F7_BASE);
          3'b011:             legal = 1'b0;
          default:            legal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        aluop = ALU_ADD;
        legal = (funct3 == F3_WORD);
      end
      OPC_BRANCH: begin
        aluop = ALU_SUB;
        legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      end
      default: begin
        aluop = ALU_ADD;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback, trap.
// Outputs are decoded from the state and the internal IR copy; reset forces
// every output to its idle value immediately.
module rv_mc_ctrl
  import rv_pkg::*;
#(
  parameter bit RESET_ILLEGAL_STICKY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  output alu_op_t     aluop,
  output logic        alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [1:0]  imm_sel,
  output logic        ir_we,
  output logic        oldpc_we,
  output logic        pc_we,
  output logic        pc_src_sel,
  output logic        rf_we,
  output logic        rf_wdata_sel,
  output logic [2:0]  state_o,
  output logic        illegal
);

  ctrl_state_t state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_t    dec_aluop;
  logic       dec_legal;
  logic       unused_ir_fields;

  assign opcode  = ir_q[6:0];
  assign funct3  = ir_q[14:12];
  assign funct7  = ir_q[31:25];
  assign state_o = state_q;

  // Register specifiers are consumed by the datapath, not by control
  assign unused_ir_fields = ^{ir_q[24:15], ir_q[11:7]};

  rv_alu_dec u_alu_dec (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .aluop  (dec_aluop),
    .legal  (dec_legal)
  );

  // State register and instruction copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and control outputs, held at idle values while reset is asserted
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    aluop        = ALU_ADD;
    alu_a_sel    = A_SEL_RS1;
    alu_b_sel    = B_SEL_RS2;
    imm_sel      = IMM_SEL_I;
    ir_we        = 1'b0;
    oldpc_we     = 1'b0;
    pc_we        = 1'b0;
    pc_src_sel   = PC_SRC_ALU;
    rf_we        = 1'b0;
    rf_wdata_sel = WD_ALUOUT;
    illegal      = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          imem_req  = 1'b1;
          alu_a_sel = A_SEL_PC;
          alu_b_sel = B_SEL_FOUR;
          if (imem_ready) begin
            ir_we      = 1'b1;
            oldpc_we   = 1'b1;
            pc_we      = 1'b1;
            pc_src_sel = PC_SRC_ALU;
            ir_d       = imem_rdata;
            state_d    = ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_a_sel = A_SEL_PC;
          alu_b_sel = B_SEL_IMM;
          imm_sel   = IMM_SEL_B;
          state_d   = dec_legal ? ST_EXEC : ST_TRAP;
        end
        ST_EXEC: begin
          case (opcode)
            OPC_RTYPE: begin
              aluop     = dec_aluop;
              alu_b_sel = B_SEL_RS2;
              state_d   = ST_WB;
            end
            OPC_ITYPE: begin
              aluop     = dec_aluop;
              alu_b_sel = B_SEL_IMM;
              imm_sel   = IMM_SEL_I;
              state_d   = ST_WB;
            end
            OPC_LOAD: begin
              alu_b_sel = B_SEL_IMM;
              imm_sel   = IMM_SEL_I;
              state_d   = ST_MEM;
            end
            OPC_STORE: begin
              alu_b_sel = B_SEL_IMM;
              imm_sel   = IMM_SEL_S;
              state_d   = ST_MEM;
            end
            OPC_BRANCH: begin
              aluop      = ALU_SUB;
              alu_b_sel  = B_SEL_RS2;
              pc_src_sel = PC_SRC_ALUOUT;
              pc_we      = (funct3 == F3_BNE) ? !alu_zero : alu_zero;
              state_d    = ST_FETCH;
            end
            default: state_d = ST_TRAP;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (opcode == OPC_STORE);
          if (dmem_ready) begin
            state_d = (opcode == OPC_STORE) ? ST_FETCH : ST_WB;
          end
        end
        ST_WB: begin
          rf_we        = 1'b1;
          rf_wdata_sel = (opcode == OPC_LOAD) ? WD_MEM : WD_ALUOUT;
          state_d      = ST_FETCH;
        end
        ST_TRAP: begin
          illegal = 1'b1;
          state_d = RESET_ILLEGAL_STICKY ? ST_TRAP : ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule
